// File: rtl/snn_timestep_scheduler.sv
// Time-step sequencer for one SNN inference run: each step advances the input spike
// generators once, then launches and awaits every hidden layer in order.
module snn_timestep_scheduler #(
    parameter  int NUM_LAYERS     = 2,
    parameter  int STEP_WIDTH     = 16,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int LAYER_IDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic                   start,
    input  logic                   abort,
    input  logic [STEP_WIDTH-1:0]  num_steps,
    output logic                   spike_gen_step,
    output logic [NUM_LAYERS-1:0]  layer_start,
    input  logic [NUM_LAYERS-1:0]  layer_done,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [STEP_WIDTH-1:0]  step_count,
    output logic [LAYER_IDX_W-1:0] cur_layer
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_LAUNCH,
        ST_WAIT,
        ST_STEP_END,
        ST_FINISH
    } state_t;

    state_t                 r_state;
    logic                   r_spike_gen_step;
    logic [NUM_LAYERS-1:0]  r_layer_start;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_timeout_err;
    logic [STEP_WIDTH-1:0]  r_step_count;
    logic [STEP_WIDTH-1:0]  r_num_steps;
    logic [LAYER_IDX_W-1:0] r_cur_layer;
    logic [WAIT_W-1:0]      r_wait_cnt;

    logic [LAYER_IDX_W-1:0] w_next_layer;
    logic [NUM_LAYERS-1:0]  w_cur_onehot;
    logic [NUM_LAYERS-1:0]  w_next_onehot;
    logic                   w_cur_done;
    logic                   w_is_last;
    logic                   w_wait_expired;
    logic [STEP_WIDTH-1:0]  w_step_inc;

    assign w_next_layer   = r_cur_layer + LAYER_IDX_W'(1);
    assign w_is_last      = (r_cur_layer == LAYER_IDX_W'(NUM_LAYERS - 1));
    assign w_wait_expired = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign w_step_inc     = r_step_count + STEP_WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_onehot
            assign w_cur_onehot[gi]  = (r_cur_layer == LAYER_IDX_W'(gi));
            assign w_next_onehot[gi] = (w_next_layer == LAYER_IDX_W'(gi));
        end
    endgenerate

    // Only the awaited layer's completion bit matters; all others are masked off.
    assign w_cur_done = |(layer_done & w_cur_onehot);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state          <= ST_IDLE;
            r_spike_gen_step <= 1'b0;
            r_layer_start    <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_timeout_err    <= 1'b0;
            r_step_count     <= '0;
            r_num_steps      <= '0;
            r_cur_layer      <= '0;
            r_wait_cnt       <= '0;
        end else begin
            r_spike_gen_step <= 1'b0;
            r_layer_start    <= '0;
            r_done           <= 1'b0;
            if (abort && r_state != ST_IDLE) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_num_steps   <= num_steps;
                            r_step_count  <= '0;
                            r_cur_layer   <= '0;
                            r_timeout_err <= 1'b0;
                            r_busy        <= 1'b1;
                            if (num_steps == '0) begin
                                r_state <= ST_FINISH;
                                r_done  <= 1'b1;
                            end else begin
                                r_state          <= ST_GEN;
                                r_spike_gen_step <= 1'b1;
                            end
                        end
                    end
                    ST_GEN: begin
                        r_state       <= ST_LAUNCH;
                        r_layer_start <= w_cur_onehot;
                    end
                    ST_LAUNCH: begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= '0;
                    end
                    ST_WAIT: begin
                        if (w_cur_done) begin
                            if (w_is_last) begin
                                r_state <= ST_STEP_END;
                            end else begin
                                r_state       <= ST_LAUNCH;
                                r_cur_layer   <= w_next_layer;
                                r_layer_start <= w_next_onehot;
                            end
                        end else if (w_wait_expired) begin
                            r_state       <= ST_IDLE;
                            r_busy        <= 1'b0;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end
                    ST_STEP_END: begin
                        r_step_count <= w_step_inc;
                        if (w_step_inc == r_num_steps) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state          <= ST_GEN;
                            r_cur_layer      <= '0;
                            r_spike_gen_step <= 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spike_gen_step = r_spike_gen_step;
    assign layer_start    = r_layer_start;
    assign busy           = r_busy;
    assign done           = r_done;
    assign timeout_err    = r_timeout_err;
    assign step_count     = r_step_count;
    assign cur_layer      = r_cur_layer;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Scoreboard bench: each run's expected trace is derived from a per-cycle timeline of the
// run (GEN, LAUNCH, WAIT..., STEP_END, FINISH) and checked when the run ends (busy falls).
module tb_snn_timestep_scheduler;
    localparam int NL  = 2;
    localparam int SW  = 16;
    localparam int TMO = 16;
    localparam int LIW = 1;

    localparam int CG = 1;
    localparam int CS = 2;
    localparam int CF = 3;
    localparam int CL = 100;
    localparam int CW = 200;

    typedef struct {
        int cycles;
        int spikes;
        int launches;
        int sig;
        int done_cnt;
        int done_idx;
        int step_count;
        int terr;
        int cur_layer;
    } rec_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [SW-1:0]  num_steps = '0;
    logic           spike;
    logic [NL-1:0]  ls;
    logic [NL-1:0]  ld = '0;
    logic           busy;
    logic           done;
    logic           terr;
    logic [SW-1:0]  sc;
    logic [LIW-1:0] cl;

    int   total = 0;
    int   bad = 0;
    int   run_no = 0;
    int   nz_mode = 0;
    int   lat_q[$];
    rec_t exp_q[$];

    snn_timestep_scheduler #(
        .NUM_LAYERS    (NL),
        .STEP_WIDTH    (SW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .start         (start),
        .abort         (abort),
        .num_steps     (num_steps),
        .spike_gen_step(spike),
        .layer_start   (ls),
        .layer_done    (ld),
        .busy          (busy),
        .done          (done),
        .timeout_err   (terr),
        .step_count    (sc),
        .cur_layer     (cl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference timeline: one entry per busy cycle, built from the step/layer rules.
    function automatic void build(input int n, input int lats[$], output int tl[$], output bit tmo);
        int k;
        int d;
        k   = 0;
        tl  = {};
        tmo = 1'b0;
        for (int s = 0; s < n && !tmo; s++) begin
            tl.push_back(CG);
            for (int l = 0; l < NL && !tmo; l++) begin
                d = lats[k];
                k++;
                tl.push_back(CL + l);
                if (d < 1 || d > TMO) begin
                    for (int w = 0; w < TMO; w++) tl.push_back(CW + l);
                    tmo = 1'b1;
                end else begin
                    for (int w = 0; w < d; w++) tl.push_back(CW + l);
                end
            end
            if (!tmo) tl.push_back(CS);
        end
        if (!tmo) tl.push_back(CF);
    endfunction

    // kind: 0 normal, 1 abort, 2 reset. sel: 1 random cycle, 2 first WAIT, 3 first WAIT of step 2.
    task automatic do_run(input int n, input int lats[$], input int kind_in, input int sel,
                          input int nz, input bit mid);
        int   tl[$];
        bit   tmo;
        bit   seen_s;
        int   len, a, tlen, ms, cur, v, kind;
        rec_t e;
        kind = kind_in;
        build(n, lats, tl, tmo);
        len = tl.size();
        a = -1;
        if (kind != 0) begin
            if (sel == 1 && len >= 2) begin
                a = $urandom_range(len - 2, 0);
            end else if (sel == 2 || sel == 3) begin
                seen_s = (sel == 2);
                for (int i = 0; i < len - 1; i++) begin
                    if (tl[i] == CS) seen_s = 1'b1;
                    if (a < 0 && seen_s && tl[i] >= CW) a = i;
                end
            end
        end
        if (a < 0) kind = 0;
        tlen = (a >= 0) ? a + 1 : len;

        e = '{default: 0};
        e.done_idx = -1;
        e.cycles = tlen;
        cur = 0;
        for (int i = 0; i < tlen; i++) begin
            v = tl[i];
            if (v == CG) begin
                e.spikes++;
                cur = 0;
            end else if (v >= CW) begin
                cur = v - CW;
            end else if (v >= CL) begin
                cur = v - CL;
                e.launches++;
                e.sig = e.sig * 3 + cur + 1;
            end else if (v == CS && i < tlen - 1) begin
                e.step_count++;
            end else if (v == CF) begin
                e.done_cnt++;
                e.done_idx = i;
            end
        end
        e.cur_layer = cur;
        e.terr = (tmo && a < 0) ? 1 : 0;
        if (kind == 2) begin
            e.step_count = 0;
            e.cur_layer  = 0;
            e.terr       = 0;
        end
        exp_q.push_back(e);

        ms = $urandom_range(tlen - 1, 0);
        nz_mode = nz;
        lat_q = lats;
        num_steps = SW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < tlen; c++) begin
            if (mid && c == ms) begin
                start = 1'b1;
                num_steps = SW'($urandom_range(9, 1));
            end
            if (c == a) begin
                if (kind == 1) abort = 1'b1;
                else rstn = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            rstn  = 1'b1;
        end
        for (int w = 0; w < 50 && busy; w++) begin
            @(posedge clk); #1;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL run_end_bound: busy still 1, required 0 within 50 cycles");
            rstn = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Layer-completion responder: raises the awaited layer's done bit in its d-th WAIT cycle.
    initial begin
        int aw_layer;
        int aw_cnt;
        int aw_d;
        aw_layer = -1;
        aw_cnt = 0;
        aw_d = 0;
        forever begin
            @(posedge clk); #1;
            if (!busy) aw_layer = -1;
            else if (aw_layer >= 0) aw_cnt++;
            if (busy && ls != '0) begin
                for (int l = 0; l < NL; l++) if (ls[l]) aw_layer = l;
                aw_cnt = 0;
                aw_d = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end
            for (int l = 0; l < NL; l++) begin
                if (l == aw_layer) ld[l] = (aw_cnt >= 1 && aw_cnt == aw_d);
                else if (nz_mode == 1) ld[l] = 1'($urandom_range(1, 0));
                else ld[l] = (nz_mode == 2);
            end
        end
    end

    // Monitor: accumulates the observed trace of a run and scores it when busy falls.
    initial begin
        rec_t act;
        rec_t e;
        bit   prev;
        int   idx;
        prev = 1'b0;
        act = '{default: 0};
        forever begin
            @(negedge clk);
            if (busy) begin
                if (!prev) begin
                    act = '{default: 0};
                    act.done_idx = -1;
                end
                if (spike) act.spikes++;
                if (ls != '0) begin
                    idx = 0;
                    for (int l = 0; l < NL; l++) if (ls[l]) idx = l;
                    act.launches++;
                    act.sig = act.sig * 3 + idx + 1;
                end
                if (done) begin
                    act.done_cnt++;
                    act.done_idx = act.cycles;
                end
                chk("onehot_pulse", int'($onehot0({spike, ls})), 1);
                act.cycles++;
            end else if (prev) begin
                act.step_count = int'(sc);
                act.terr = int'(terr);
                act.cur_layer = int'(cl);
                run_no++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_run_end: got run %0d, required no run", run_no);
                end else begin
                    e = exp_q.pop_front();
                    $display("run %0d: cycles=%0d spikes=%0d launches=%0d done_at=%0d step_count=%0d terr=%0d",
                             run_no, act.cycles, act.spikes, act.launches, act.done_idx,
                             act.step_count, act.terr);
                    chk("cycles", act.cycles, e.cycles);
                    chk("spikes", act.spikes, e.spikes);
                    chk("launches", act.launches, e.launches);
                    chk("launch_order", act.sig, e.sig);
                    chk("done_pulses", act.done_cnt, e.done_cnt);
                    chk("done_cycle", act.done_idx, e.done_idx);
                    chk("step_count", act.step_count, e.step_count);
                    chk("timeout_err", act.terr, e.terr);
                    chk("cur_layer", act.cur_layer, e.cur_layer);
                    chk("idle_pulses", int'({spike, ls, done}), 0);
                end
            end else begin
                chk("idle_done", int'(done), 0);
            end
            prev = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int r, n, kind;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_spike", int'(spike), 0);
        chk("rst_layer_start", int'(ls), 0);
        chk("rst_timeout_err", int'(terr), 0);
        chk("rst_step_count", int'(sc), 0);
        chk("rst_cur_layer", int'(cl), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        q = {1, 1, 1, 1, 1, 1};
        do_run(3, q, 0, 0, 0, 1'b0);
        q = {};
        do_run(0, q, 0, 0, 0, 1'b0);
        q = {1, 0};
        do_run(2, q, 0, 0, 0, 1'b0);
        q = {2, 3};
        do_run(1, q, 0, 0, 0, 1'b0);
        q = {16, 1};
        do_run(1, q, 0, 0, 1, 1'b0);
        q = {1, 2, 3, 1, 2, 3};
        do_run(3, q, 1, 3, 0, 1'b1);
        q = {4, 2, 3, 1};
        do_run(2, q, 0, 0, 2, 1'b0);
        q = {3, 3, 3, 3};
        do_run(2, q, 2, 2, 0, 1'b0);
        q = {1, 2, 2, 1};
        do_run(2, q, 0, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(4, 0);
            q = {};
            for (int i = 0; i < n * NL; i++) begin
                r = $urandom_range(19, 0);
                q.push_back((r == 0) ? 0 : (r == 1) ? 16 : (r % 6) + 1);
            end
            r = $urandom_range(19, 0);
            kind = (r < 4) ? 1 : (r == 4) ? 2 : 0;
            do_run(n, q, kind, 1, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_runs: got %0d unscored, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
